// File: rtl/fp16_operand_unpack.sv
// Purpose : unpack an FP16 operand stream into sign, unbiased exponent and an
//           explicit-leading-one mantissa; subnormals pre-normalised.
// Latency : 2 cycles input transfer -> out_valid, 1 operand/cycle throughput.
// Backpressure: in_ready = !s1_valid || !s2_valid || out_ready; stalled stages hold data.
//
// Ports: clk/rst_n (async active-low); in_data/in_valid/in_ready input stream;
//        out_sign/out_exp/out_man/out_zero/out_special/out_idx/out_last with
//        out_valid/out_ready output stream.
// Optional: define FP16_OPERAND_UNPACK_STATS_EN to add stat_zero_cnt,
//           stat_sub_cnt, stat_special_cnt (16-bit saturating output counters).
module fp16_operand_unpack #(
    parameter int VEC_LEN = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_sign,
    output logic [6:0]       out_exp,
    output logic [10:0]      out_man,
    output logic             out_zero,
    output logic             out_special,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
`ifdef FP16_OPERAND_UNPACK_STATS_EN
    ,
    output logic [15:0]      stat_zero_cnt,
    output logic [15:0]      stat_sub_cnt,
    output logic [15:0]      stat_special_cnt
`endif
);

    // Leading-zero count of the 10-bit fraction (only meaningful for nonzero input).
    function automatic logic [3:0] lzc10(input logic [9:0] f);
        logic [3:0] n;
        logic       found;
        n     = 4'd0;
        found = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            if (!found) begin
                if (f[i]) found = 1'b1;
                else      n = n + 4'd1;
            end
        end
        return n;
    endfunction

    // Stage 1 state
    logic       s1_valid;
    logic       s1_sign;
    logic [4:0] s1_exp;
    logic [9:0] s1_frac;
    logic       s1_zero;
    logic       s1_sub;
    logic       s1_special;
    logic [3:0] s1_lzc;

    logic             s2_valid;
    logic [IDX_W-1:0] idx_cnt;

    logic in_xfer;
    logic s2_load;

    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign out_valid = s2_valid;
    assign out_last  = (out_idx == IDX_W'(VEC_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= 5'd0;
            s1_frac    <= 10'd0;
            s1_zero    <= 1'b0;
            s1_sub     <= 1'b0;
            s1_special <= 1'b0;
            s1_lzc     <= 4'd0;
        end else begin
            if (in_xfer) begin
                s1_valid   <= 1'b1;
                s1_sign    <= in_data[15];
                s1_exp     <= in_data[14:10];
                s1_frac    <= in_data[9:0];
                s1_zero    <= (in_data[14:10] == 5'd0) && (in_data[9:0] == 10'd0);
                s1_sub     <= (in_data[14:10] == 5'd0) && (in_data[9:0] != 10'd0);
                s1_special <= (in_data[14:10] == 5'd31);
                s1_lzc     <= lzc10(in_data[9:0]);
            end else if (s2_load) begin
                s1_valid   <= 1'b0;
            end
        end
    end

    // Shifting by lzc+1 pushes the first set fraction bit into bit 10.
    logic [10:0] sub_man;
    logic [10:0] n_man;
    logic [6:0]  n_exp;

    assign sub_man = {1'b0, s1_frac} << (s1_lzc + 4'd1);

    always_comb begin
        n_man = {1'b1, s1_frac};
        n_exp = {2'b00, s1_exp} - 7'd15;
        if (s1_zero) begin
            n_man = 11'd0;
            n_exp = 7'd0;
        end else if (s1_special) begin
            n_exp = 7'd16;
        end else if (s1_sub) begin
            n_man = sub_man;
            n_exp = 7'd113 - {3'b000, s1_lzc};   // -15 - lzc in 7-bit two's complement
        end
    end

`ifdef FP16_OPERAND_UNPACK_STATS_EN
    logic s2_sub;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= 7'd0;
            out_man     <= 11'd0;
            out_zero    <= 1'b0;
            out_special <= 1'b0;
            out_idx     <= '0;
            idx_cnt     <= '0;
`ifdef FP16_OPERAND_UNPACK_STATS_EN
            s2_sub      <= 1'b0;
`endif
        end else begin
            if (s2_load) begin
                s2_valid    <= 1'b1;
                out_sign    <= s1_sign;
                out_exp     <= n_exp;
                out_man     <= n_man;
                out_zero    <= s1_zero;
                out_special <= s1_special;
                out_idx     <= idx_cnt;
                idx_cnt     <= (idx_cnt == IDX_W'(VEC_LEN - 1)) ? '0 : idx_cnt + IDX_W'(1);
`ifdef FP16_OPERAND_UNPACK_STATS_EN
                s2_sub      <= s1_sub;
`endif
            end else if (out_ready) begin
                s2_valid    <= 1'b0;
            end
        end
    end

`ifdef FP16_OPERAND_UNPACK_STATS_EN
    logic out_xfer;
    assign out_xfer = s2_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_zero_cnt    <= 16'd0;
            stat_sub_cnt     <= 16'd0;
            stat_special_cnt <= 16'd0;
        end else if (out_xfer) begin
            if (out_zero && stat_zero_cnt != 16'hFFFF)
                stat_zero_cnt <= stat_zero_cnt + 16'd1;
            if (s2_sub && stat_sub_cnt != 16'hFFFF)
                stat_sub_cnt <= stat_sub_cnt + 16'd1;
            if (out_special && stat_special_cnt != 16'hFFFF)
                stat_special_cnt <= stat_special_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp16_operand_unpack.sv
// Purpose : directed check of fp16_operand_unpack against hand-computed vectors.
// Latency : scoreboard tracks accepted operands and matches them in order at the output.
// Backpressure: exercises stall, release, throughput and asynchronous reset mid-stream.
module tb_fp16_operand_unpack;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_sign;
    logic [6:0]  out_exp;
    logic [10:0] out_man;
    logic        out_zero;
    logic        out_special;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    fp16_operand_unpack #(.VEC_LEN(16), .IDX_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_sign    (out_sign),
        .out_exp     (out_exp),
        .out_man     (out_man),
        .out_zero    (out_zero),
        .out_special (out_special),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] din;
        logic        sign;
        logic [6:0]  exp;
        logic [10:0] man;
        logic        zero;
        logic        spec;
    } vec_t;

    vec_t tbl [12];
    int   sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_k = 0;
    int   out_cnt = 0;
    int   xfer_total = 0;
    int   cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor / scoreboard, sampled on the falling edge.
    int mk;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            out_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    mk = sb.pop_front();
                    check("sign",    32'(out_sign),    32'(tbl[mk].sign));
                    check("exp",     32'(out_exp),     32'(tbl[mk].exp));
                    check("man",     32'(out_man),     32'(tbl[mk].man));
                    check("zero",    32'(out_zero),    32'(tbl[mk].zero));
                    check("special", 32'(out_special), 32'(tbl[mk].spec));
                    check("idx",     32'(out_idx),     32'(out_cnt % 16));
                    check("last",    32'(out_last),    32'((out_cnt % 16) == 15));
                end
                out_cnt++;
                xfer_total++;
            end
            if (in_valid && in_ready) sb.push_back(cur_k);
        end
    end

    task automatic send(input int k);
        int n;
        n        = 0;
        cur_k    = k;
        in_data  = tbl[k].din;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    logic [31:0] snap;
    int acc, c0, x0;
    logic got_rdy;

    initial begin
        //                din       s     exp     man      z     sp
        tbl[0]  = '{16'h3C00, 1'b0, 7'h00, 11'h400, 1'b0, 1'b0};
        tbl[1]  = '{16'h0001, 1'b0, 7'h68, 11'h400, 1'b0, 1'b0};
        tbl[2]  = '{16'h03FF, 1'b0, 7'h71, 11'h7FE, 1'b0, 1'b0};
        tbl[3]  = '{16'h0200, 1'b0, 7'h71, 11'h400, 1'b0, 1'b0};
        tbl[4]  = '{16'h8000, 1'b1, 7'h00, 11'h000, 1'b1, 1'b0};
        tbl[5]  = '{16'h7C00, 1'b0, 7'h10, 11'h400, 1'b0, 1'b1};
        tbl[6]  = '{16'hFE00, 1'b1, 7'h10, 11'h600, 1'b0, 1'b1};
        tbl[7]  = '{16'h0400, 1'b0, 7'h72, 11'h400, 1'b0, 1'b0};
        tbl[8]  = '{16'h7BFF, 1'b0, 7'h0F, 11'h7FF, 1'b0, 1'b0};
        tbl[9]  = '{16'hC500, 1'b1, 7'h02, 11'h500, 1'b0, 1'b0};
        tbl[10] = '{16'h0010, 1'b0, 7'h6C, 11'h400, 1'b0, 1'b0};
        tbl[11] = '{16'h0000, 1'b0, 7'h00, 11'h000, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_man",   32'(out_man),   32'd0);
        check("rst_out_exp",   32'(out_exp),   32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // First operand: not valid one cycle after transfer, valid the next.
        send(0);
        @(negedge clk);
        check("lat_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        for (int k = 1; k < 12; k++) send(k);
        drain();

        // Back-to-back stream starting at element index 0.
        do_reset();
        @(posedge clk);
        #1;
        c0 = cyc;
        x0 = xfer_total;
        for (int i = 0; i < 20; i++) send(i % 12);
        check("stream_in_cycles", 32'(cyc - c0), 32'd20);
        check("stream_out_fill",  32'(xfer_total - x0), 32'd18);
        repeat (2) @(posedge clk);
        #1;
        check("stream_out_all",   32'(xfer_total - x0), 32'd20);
        drain();

        // Backpressure from an empty pipe: two accepts then in_ready drops.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            cur_k    = acc;
            in_data  = tbl[acc].din;
            @(negedge clk);
            got_rdy = in_ready;
            @(posedge clk);
            #1;
            if (got_rdy) acc++;
        end
        check("bp_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid",    32'(out_valid), 32'd1);
        snap = {6'd0, out_sign, out_exp, out_man, out_zero, out_special, out_idx, out_last};
        @(negedge clk);
        check("bp_stable", {6'd0, out_sign, out_exp, out_man, out_zero, out_special, out_idx, out_last}, snap);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 2; k < 8; k++) send(k);
        drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        send(8);
        send(9);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready",  32'(in_ready),  32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_idx",   32'(out_idx),   32'd0);
        check("arst_out_man",   32'(out_man),   32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(5);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_idx",   32'(out_idx),   32'd0);
        @(posedge clk);
        #1;
        drain();
        check("total_after_rst", 32'(out_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_operand_unpack.md
Name: fp16_operand_unpack

Overview:
- Front end of the MAC subsystem; the inverse of the final exponent/normalisation packing stage.
- Accepts a stream of IEEE FP16 operands on a valid/ready interface.
- Unpacks each operand into sign, unbiased signed exponent and an 11-bit mantissa with the leading 1 made explicit. Subnormals are pre-normalised, so the multiplier/aligner never sees a hidden-bit-zero mantissa.
- Two-stage pipeline with full backpressure and a per-vector element index and last flag.

Parameters:
- VEC_LEN, 16, elements per MAC vector; out_last marks element VEC_LEN-1.
- IDX_W, 4, width of out_idx; must satisfy 2^IDX_W >= VEC_LEN.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  16  FP16 operand {sign, exp[4:0], frac[9:0]}
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept in_data this cycle
- out_sign  output  1  operand sign
- out_exp  output  7  signed unbiased exponent, two's complement
- out_man  output  11  mantissa with leading 1 at bit 10 (0 for zero)
- out_zero  output  1  operand is +0 or -0
- out_special  output  1  exp field = 31 (Inf/NaN)
- out_idx  output  IDX_W  element index within the current vector
- out_last  output  1  out_idx == VEC_LEN-1
- out_valid  output  1  out_* fields valid
- out_ready  input  1  downstream accepts this cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both stage valids clear; out_valid = 0.
  - All out_* data fields = 0; idx counter = 0.
  - in_ready = 1 from the first cycle after release.
- Handshakes:
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready. It is combinational from out_ready only.
  - Data held in a stage never changes while that stage is stalled.
- Stage 1, classify (register):
  - Latches sign, exp, frac.
  - Computes zero = (exp==0 && frac==0), sub = (exp==0 && frac!=0), special = (exp==31).
  - Computes lzc = leading-zero count of frac (0..9, valid only when sub).
- Stage 2, normalise (register = outputs):
  - normal: out_man = {1, frac}; out_exp = exp - 15 (range -14..+15).
  - sub: out_man = frac << (lzc+1); out_exp = -15 - lzc (range -15..-24).
  - zero: out_man = 0; out_exp = 0; out_zero = 1; out_sign keeps the input sign.
  - special: out_special = 1; out_man = {1, frac}; out_exp = +16. The downstream block owns the Inf/NaN policy.
- Pipeline advance:
  - s2 loads from s1 when s1_valid && (!s2_valid || out_ready).
  - s1 loads from input on an input transfer.
  - Both stages may advance in the same cycle.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to out_valid when unstalled.
  - Throughput is 1 operand per cycle.
- Index counter:
  - out_idx is the s2 element index, assigned when the element enters s2.
  - The counter increments per element entering s2 and wraps VEC_LEN-1 -> 0.
  - out_last = (out_idx == VEC_LEN-1).
- Boundaries:
  - Pipeline full and out_ready = 0: in_ready = 0, outputs frozen.
  - out_ready rising while full: s2 drains, s1 -> s2 and a new input -> s1 in the same cycle.
  - Reset mid-vector: the counter returns to 0 and in-flight data is discarded.

Optional Feature:
- Macro FP16_OPERAND_UNPACK_STATS_EN.
- When defined, adds three output ports: stat_zero_cnt, stat_sub_cnt, stat_special_cnt, each 16 bits.
  - Each counter increments on every output transfer of that class.
  - Counters saturate at 0xFFFF and reset to 0 on rst_n.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- 0x3C00, out_ready=1 -> 2 cycles later: sign 0, exp 0, man 0x400, zero 0, special 0, idx 0.
- Subnormals:
  - 0x0001 -> exp -24 (0x68), man 0x400.
  - 0x03FF -> exp -15 (0x71), man 0x7FE.
  - 0x0200 -> exp -15, man 0x400.
- Zero and special:
  - 0x8000 -> sign 1, zero 1, man 0, exp 0.
  - 0x7C00 -> special 1, exp +16, man 0x400.
  - 0xFE00 -> sign 1, special 1, man 0x600.
- Stream 20 back-to-back operands with out_ready=1:
  - One out_valid per cycle after a 2-cycle fill.
  - out_idx runs 0..15, 0..3; out_last on the 16th element only.
- Backpressure:
  - out_ready=0 for 5 cycles mid-stream: in_ready drops after 2 accepted items, out_* stable.
  - On release: no loss or duplication, order preserved.
- Reset mid-operation:
  - Assert rst_n=0 with both stages full -> out_valid=0 immediately (asynchronous), idx=0.
  - After release, the first new operand emerges with out_idx 0.
